// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_stage_reg
//  Purpose  : Parameterised pipeline-register chain. A WIDTH-bit payload moves
//             through STAGES register slots under valid/ready handshakes.
//             Empty slots keep accepting while downstream stalls, so gaps close
//             up. Flush is synchronous and kills all in-flight beats. A
//             registered counter tracks how many slots are valid.
//  Ports    : clk        - clock, all state updates on the rising edge
//             reset      - synchronous, active-high reset
//             flush      - synchronous kill of all in-flight entries
//             in_valid   - upstream presents a beat
//             in_data    - upstream payload
//             in_ready   - chain accepts a beat this cycle
//             out_valid  - last slot holds a valid beat
//             out_data   - payload of the last slot
//             out_ready  - downstream accepts a beat this cycle
//             occupancy  - number of valid slots (0..STAGES)
//  Revision : 1.0 - initial release
// ============================================================================
module pipe_stage_reg #(
    parameter int WIDTH          = 32,
    parameter int STAGES         = 1,
    parameter int CLEAR_ON_FLUSH = 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         flush,
    input  logic                         in_valid,
    input  logic [WIDTH-1:0]             in_data,
    output logic                         in_ready,
    output logic                         out_valid,
    output logic [WIDTH-1:0]             out_data,
    input  logic                         out_ready,
    output logic [$clog2(STAGES+1)-1:0]  occupancy
);

    localparam int c_OCC_W = $clog2(STAGES + 1);

    // Slot 0 is the input side, slot STAGES-1 drives the outputs.
    logic               r_v [STAGES];
    logic [WIDTH-1:0]   r_d [STAGES];
    logic [c_OCC_W-1:0] r_occ;

    logic [STAGES-1:0]  w_rdy;
    logic               w_hole;
    logic               w_in_xfer;
    logic               w_out_xfer;

    // A slot may load this edge when it, or any slot between it and the
    // output, is empty, or when the output side is being drained. This is
    // what lets bubbles collapse while downstream is stalled.
    always_comb begin
        w_hole = 1'b0;
        w_rdy  = '0;
        for (int i = STAGES - 1; i >= 0; i--) begin
            w_hole   = w_hole | ~r_v[i];
            w_rdy[i] = w_hole | out_ready;
        end
    end

    assign in_ready   = w_rdy[0] & ~flush & ~reset;
    assign w_in_xfer  = in_valid & in_ready;
    assign w_out_xfer = r_v[STAGES-1] & out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < STAGES; i++) begin
                r_v[i] <= 1'b0;
                r_d[i] <= '0;
            end
            r_occ <= '0;
        end else if (flush) begin
            for (int i = 0; i < STAGES; i++) begin
                r_v[i] <= 1'b0;
                if (CLEAR_ON_FLUSH != 0) begin
                    r_d[i] <= '0;
                end
            end
            r_occ <= '0;
        end else begin
            if (w_rdy[0]) begin
                r_v[0] <= in_valid;
                if (in_valid) begin
                    r_d[0] <= in_data;
                end
            end
            // Data only moves with a valid beat, so an invalid slot keeps its
            // last payload and out_data never changes on a bubble.
            for (int i = 1; i < STAGES; i++) begin
                if (w_rdy[i]) begin
                    r_v[i] <= r_v[i-1];
                    if (r_v[i-1]) begin
                        r_d[i] <= r_d[i-1];
                    end
                end
            end
            r_occ <= r_occ + c_OCC_W'(w_in_xfer) - c_OCC_W'(w_out_xfer);
        end
    end

    assign out_valid = r_v[STAGES-1];
    assign out_data  = r_d[STAGES-1];
    assign occupancy = r_occ;

endmodule
`default_nettype wire
